// File: rtl/nios_sys_key_pkg.sv
// Shared types and constants for the push-button debouncer.
// Imported by the per-channel debouncer and its top-level wrapper.
package nios_sys_key_pkg;

  typedef enum logic [1:0] {
    REL,
    CHK_P,
    PRS,
    CHK_R
  } key_db_state_t;

  localparam int unsigned KEY_DB_DEFAULT_CYCLES = 1_000_000;

endpackage

// File: rtl/nios_sys_key_debounce_ch.sv
// One push-button channel: two-flop synchronizer, stability
// counter, press/release FSM and registered one-cycle strobes.
module nios_sys_key_debounce_ch
  import nios_sys_key_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DB_DEFAULT_CYCLES
) (
  input  logic clk,
  input  logic reset,
  input  logic key_raw,
  output logic key_out,
  output logic key_press,
  output logic key_release
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  logic          s1_q;
  logic          s2_q;
  key_db_state_t state_q;
  key_db_state_t state_d;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          out_q;
  logic          out_d;
  logic          prs_q;
  logic          prs_d;
  logic          rel_q;
  logic          rel_d;

  // Synchronize the raw pad; only s1 may go metastable.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= key_raw;
      s2_q <= s1_q;
    end
  end

  // State, counter, level and strobe registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= REL;
      cnt_q   <= '0;
      out_q   <= 1'b1;
      prs_q   <= 1'b0;
      rel_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      prs_q   <= prs_d;
      rel_q   <= rel_d;
    end
  end

  // Next state: a new level must hold for DEBOUNCE_CYCLES samples.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    prs_d   = 1'b0;
    rel_d   = 1'b0;
    unique case (state_q)
      REL: begin
        if (!s2_q) begin
          state_d = CHK_P;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_P: begin
        if (s2_q) begin
          state_d = REL;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = PRS;
          cnt_d   = '0;
          out_d   = 1'b0;
          prs_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      PRS: begin
        if (s2_q) begin
          state_d = CHK_R;
          cnt_d   = CNT_ONE;
        end
      end
      CHK_R: begin
        if (!s2_q) begin
          state_d = PRS;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = REL;
          cnt_d   = '0;
          out_d   = 1'b1;
          rel_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = REL;
        cnt_d   = '0;
      end
    endcase
  end

  assign key_out     = out_q;
  assign key_press   = prs_q;
  assign key_release = rel_q;

endmodule

// File: rtl/nios_sys_key_debounce.sv
// Board push-button conditioner feeding the key PIO in_port.
// WIDTH identical, independent debounce channels.
module nios_sys_key_debounce
  import nios_sys_key_pkg::*;
#(
  parameter int unsigned WIDTH           = 4,
  parameter int unsigned DEBOUNCE_CYCLES = KEY_DB_DEFAULT_CYCLES
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] key_raw,
  output logic [WIDTH-1:0] key_out,
  output logic [WIDTH-1:0] key_press,
  output logic [WIDTH-1:0] key_release
);

  if (WIDTH < 1) begin : g_bad_width
    $error("nios_sys_key_debounce: WIDTH must be >= 1");
  end

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_cycles
    $error("nios_sys_key_debounce: DEBOUNCE_CYCLES must be >= 2");
  end

  for (genvar i = 0; i < WIDTH; i++) begin : g_ch
    nios_sys_key_debounce_ch #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .key_raw    (key_raw[i]),
      .key_out    (key_out[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i])
    );
  end

endmodule

// File: tb/tb_nios_sys_key_debounce.sv
// Self-checking bench for nios_sys_key_debounce (WIDTH=4, 8 cycles).
// Reference: a level flips after DC consecutive differing samples.
module tb_nios_sys_key_debounce;

  localparam int DC = 8;
  localparam int W  = 4;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] key_raw;
  logic [W-1:0] key_out;
  logic [W-1:0] key_press;
  logic [W-1:0] key_release;

  int cmp_cnt = 0;
  int err_cnt = 0;

  nios_sys_key_debounce #(
    .WIDTH          (W),
    .DEBOUNCE_CYCLES(DC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .key_raw    (key_raw),
    .key_out    (key_out),
    .key_press  (key_press),
    .key_release(key_release)
  );

  always #5 clk = ~clk;

  // Reference: raw reaches the sampler two clocks late; a channel
  // accepts a new level once DC successive samples disagree with it.
  logic [W-1:0] m_d1, m_d2, m_out, m_prs, m_rel;
  int           m_run [W];

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_d1  <= '1;
      m_d2  <= '1;
      m_out <= '1;
      m_prs <= '0;
      m_rel <= '0;
      for (int i = 0; i < W; i++) m_run[i] <= 0;
    end else begin
      m_d1 <= key_raw;
      m_d2 <= m_d1;
      for (int i = 0; i < W; i++) begin
        m_prs[i] <= 1'b0;
        m_rel[i] <= 1'b0;
        if (m_d2[i] != m_out[i]) begin
          if (m_run[i] + 1 == DC) begin
            m_out[i] <= m_d2[i];
            m_prs[i] <= ~m_d2[i];
            m_rel[i] <= m_d2[i];
            m_run[i] <= 0;
          end else begin
            m_run[i] <= m_run[i] + 1;
          end
        end else begin
          m_run[i] <= 0;
        end
      end
    end
  end

  task automatic test_reset();
    logic [W-1:0] eo, ep;
    reset   = 1'b1;
    key_raw = 4'hE;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (key_out !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0) begin
      err_cnt++;
      $display("FAIL reset_hold: out=%h prs=%h rel=%h required F/0/0",
               key_out, key_press, key_release);
    end
    reset = 1'b0;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      eo = (i >= 10) ? 4'hE : 4'hF;
      ep = (i == 10) ? 4'h1 : 4'h0;
      cmp_cnt++;
      if (key_out !== eo || key_press !== ep || key_release !== 4'h0) begin
        err_cnt++;
        $display("FAIL reset_held_press e%0d: out=%h prs=%h rel=%h required %h/%h/0",
                 i, key_out, key_press, key_release, eo, ep);
      end
    end
    key_raw = 4'hF;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if ({key_out, key_press, key_release} !== {m_out, m_prs, m_rel}) begin
        err_cnt++;
        $display("FAIL reset_settle c%0d: got %h/%h/%h required %h/%h/%h",
                 i, key_out, key_press, key_release, m_out, m_prs, m_rel);
      end
    end
  endtask

  task automatic test_press_release();
    logic [W-1:0] eo, es;
    key_raw = 4'hD;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      eo = (i >= 10) ? 4'hD : 4'hF;
      es = (i == 10) ? 4'h2 : 4'h0;
      cmp_cnt++;
      if (key_out !== eo || key_press !== es || key_release !== 4'h0) begin
        err_cnt++;
        $display("FAIL press e%0d: out=%h prs=%h rel=%h required %h/%h/0",
                 i, key_out, key_press, key_release, eo, es);
      end
    end
    key_raw = 4'hF;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      eo = (i >= 10) ? 4'hF : 4'hD;
      es = (i == 10) ? 4'h2 : 4'h0;
      cmp_cnt++;
      if (key_out !== eo || key_release !== es || key_press !== 4'h0) begin
        err_cnt++;
        $display("FAIL release e%0d: out=%h prs=%h rel=%h required %h/0/%h",
                 i, key_out, key_press, key_release, eo, es);
      end
    end
  endtask

  task automatic test_bounce();
    key_raw = 4'hB;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (i == 7) key_raw = 4'hF;
      cmp_cnt++;
      if (key_out !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0) begin
        err_cnt++;
        $display("FAIL bounce7 c%0d: out=%h prs=%h rel=%h required F/0/0",
                 i, key_out, key_press, key_release);
      end
    end
    key_raw = 4'hB;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 8) key_raw = 4'hF;
    end
    cmp_cnt++;
    if (key_out !== 4'hB || key_press !== 4'h4) begin
      err_cnt++;
      $display("FAIL bounce8: out=%h prs=%h required B/4", key_out, key_press);
    end
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if ({key_out, key_press, key_release} !== {m_out, m_prs, m_rel}) begin
        err_cnt++;
        $display("FAIL bounce_settle c%0d: got %h/%h/%h required %h/%h/%h",
                 i, key_out, key_press, key_release, m_out, m_prs, m_rel);
      end
    end
  endtask

  task automatic test_chatter();
    for (int i = 0; i < 100; i++) begin
      key_raw = {((i / 3) % 2 == 0) ? 1'b0 : 1'b1, 3'b111};
      @(negedge clk);
      cmp_cnt++;
      if (key_out !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0) begin
        err_cnt++;
        $display("FAIL chatter c%0d: out=%h prs=%h rel=%h required F/0/0",
                 i, key_out, key_press, key_release);
      end
    end
    key_raw = 4'hF;
    repeat (4) @(negedge clk);
  endtask

  task automatic test_simultaneous();
    logic [W-1:0] eo, ep;
    key_raw = 4'h0;
    for (int i = 1; i <= 11; i++) begin
      @(negedge clk);
      eo = (i >= 10) ? 4'h0 : 4'hF;
      ep = (i == 10) ? 4'hF : 4'h0;
      cmp_cnt++;
      if (key_out !== eo || key_press !== ep || key_release !== 4'h0) begin
        err_cnt++;
        $display("FAIL simul e%0d: out=%h prs=%h rel=%h required %h/%h/0",
                 i, key_out, key_press, key_release, eo, ep);
      end
    end
    key_raw = 4'hF;
    for (int i = 0; i < 14; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if ({key_out, key_press, key_release} !== {m_out, m_prs, m_rel}) begin
        err_cnt++;
        $display("FAIL simul_release c%0d: got %h/%h/%h required %h/%h/%h",
                 i, key_out, key_press, key_release, m_out, m_prs, m_rel);
      end
    end
  endtask

  task automatic test_reset_mid();
    key_raw = 4'hE;
    repeat (5) @(negedge clk);
    reset = 1'b1;
    #1;
    cmp_cnt++;
    if (key_out !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0) begin
      err_cnt++;
      $display("FAIL reset_mid: out=%h prs=%h rel=%h required F/0/0",
               key_out, key_press, key_release);
    end
    key_raw = 4'hF;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      cmp_cnt++;
      if (key_out !== 4'hF || key_press !== 4'h0 || key_release !== 4'h0) begin
        err_cnt++;
        $display("FAIL reset_mid_after c%0d: out=%h prs=%h rel=%h required F/0/0",
                 i, key_out, key_press, key_release);
      end
    end
  endtask

  task automatic test_random();
    int hold [W];
    for (int c = 0; c < W; c++) hold[c] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < W; c++) begin
        if (hold[c] == 0) begin
          key_raw[c] = 1'($urandom_range(0, 1));
          hold[c]    = $urandom_range(1, 12);
        end
        hold[c]--;
      end
      @(negedge clk);
      cmp_cnt++;
      if ({key_out, key_press, key_release} !== {m_out, m_prs, m_rel}) begin
        err_cnt++;
        $display("FAIL random c%0d: got %h/%h/%h required %h/%h/%h",
                 i, key_out, key_press, key_release, m_out, m_prs, m_rel);
      end
      cmp_cnt++;
      if ((key_press & key_release) !== 4'h0) begin
        err_cnt++;
        $display("FAIL random_excl c%0d: prs=%h rel=%h required disjoint",
                 i, key_press, key_release);
      end
    end
  endtask

  initial begin
    reset   = 1'b1;
    key_raw = 4'hF;
    test_reset();
    test_press_release();
    test_bounce();
    test_chatter();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/nios_sys_key_debounce.md
# nios_sys_key_debounce

Per-channel synchronizer, debouncer and edge detector for the board push-buttons. It sits directly upstream of the key PIO input port: raw asynchronous pad levels go in, and clean, glitch-free levels come out to drive the PIO `in_port`. One-cycle press and release strobes are also produced for any logic that needs edge events. Output polarity matches the pads (active-low, 1 = released), so software reading the PIO is unaffected.

## Interface
- `WIDTH`, default 4: number of key channels.
- `DEBOUNCE_CYCLES`, default 1_000_000: consecutive stable samples needed to accept a new level (20 ms at 50 MHz). Must be ≥ 2.
- `clk`  in  1: system clock; the block uses one clock only.
- `reset`  in  1: asynchronous, active-high reset.
- `key_raw`  in  WIDTH: raw button pads, asynchronous, active-low.
- `key_out`  out  WIDTH: debounced level, active-low; drives the PIO `in_port`.
- `key_press`  out  WIDTH: one-cycle strobe on an accepted 1→0 transition.
- `key_release`  out  WIDTH: one-cycle strobe on an accepted 0→1 transition.

## Operation
- Channels are fully independent and identical.
- **Synchronizer:** two flops per channel, `s1` then `s2`. Both reset to 1.
- **Counter:** `cnt` per channel, width `$clog2(DEBOUNCE_CYCLES)`. It saturates logically and never wraps, because it is cleared before it can reach `DEBOUNCE_CYCLES`.
- **States** per channel, reset state `REL`:
  - `REL`: `key_out`=1.
    - `s2`=0 → `CHK_P`, `cnt`=1.
  - `CHK_P`: `key_out`=1.
    - `s2`=1 → `REL`, `cnt`=0, no strobe (bounce rejected).
    - `s2`=0 and `cnt`==`DEBOUNCE_CYCLES`-1 → `PRS`, `key_out`←0, `key_press`←1.
    - Otherwise `cnt`++.
  - `PRS`: `key_out`=0.
    - `s2`=1 → `CHK_R`, `cnt`=1.
  - `CHK_R`: `key_out`=0.
    - `s2`=0 → `PRS`, `cnt`=0, no strobe.
    - `s2`=1 and `cnt`==`DEBOUNCE_CYCLES`-1 → `REL`, `key_out`←1, `key_release`←1.
    - Otherwise `cnt`++.
- **Strobes:** `key_press` and `key_release` are registered and high for exactly one cycle. They are never both high on the same channel.
- **Reset values:** `key_out` = all ones; `key_press` = 0; `key_release` = 0; all states `REL`; `cnt` = 0.
- **Reset mid-operation:** any pending check is abandoned with no strobe. A key still held when reset is released is reported as a fresh press after the full latency.
- **Simultaneous changes:** channels changing on the same cycle commit on the same edge, and their strobes assert together.

## Timing
- **Acceptance:** a level is accepted after `DEBOUNCE_CYCLES` consecutive equal `s2` samples.
- **Latency:** edge 0 is the first edge at which `s1` captures the new raw level. `key_out` and the strobe update on edge `DEBOUNCE_CYCLES`+1, i.e. the `DEBOUNCE_CYCLES`+2-th edge.
- **Glitch rejection:** a raw glitch held for ≤ `DEBOUNCE_CYCLES`-1 cycles is rejected. A level held for ≥ `DEBOUNCE_CYCLES` cycles is accepted.
- **Data path:** no combinational path from `key_raw` to any output. All outputs are registered.
- **Raw input:** `key_raw` may violate setup and hold. Only `s1` may go metastable.

## Structure
- **Package `nios_sys_key_pkg`:**
  - State enum `key_db_state_t` with values `REL`, `CHK_P`, `PRS`, `CHK_R`.
  - Constant `KEY_DB_DEFAULT_CYCLES` = 1_000_000.
- **Sub-module `nios_sys_key_debounce_ch`:** one channel, containing the synchronizer, counter, FSM and strobe generation.
- **Top level:** a generate loop of `WIDTH` instances, plus checks on the parameters.

## Test plan
All scenarios use `WIDTH`=4 and `DEBOUNCE_CYCLES`=8.
- **Reset:**
  - While `reset`=1, with `key_raw`=4'hE → `key_out`=4'hF, strobes 0.
  - Release `reset` with the key still held → `key_out`=4'hE on the 10th edge, and `key_press`=4'h1 for one cycle.
- **Clean press/release:**
  - `key_raw` 4'hF→4'hD held → `key_out`=4'hD on the 10th edge, `key_press`=4'h2 for one cycle.
  - Return `key_raw` to 4'hF → `key_out`=4'hF on the 10th edge, `key_release`=4'h2 for one cycle.
- **Bounce:**
  - `key_raw[2]` low for 7 cycles then high → `key_out` stays 4'hF, no strobes.
  - Repeat with 8 cycles low → `key_out[2]`=0 on the 10th edge.
- **Chatter:** `key_raw[3]` toggles every 3 cycles for 100 cycles → no strobes, `key_out`=4'hF.
- **Simultaneous:** `key_raw` 4'hF→4'h0 → `key_out`=4'h0 on a single edge, and `key_press`=4'hF for one cycle.
- **Reset mid-check:** assert `reset` 5 cycles after `key_raw[0]` falls → `key_out`=4'hF immediately, no strobe.
